dff_pipe_reg: RTL and testbench

//  Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage
//  D-flip-flop delay line with a per-stage valid bit, a shift enable (stall), a flush
//  and an occupancy counter. Used to retime or delay data/valid pairs between blocks.

---
 rtl/dff_pipe_reg_pkg.sv | 29 ++
 rtl/dff_en_stage.sv | 36 +++
 rtl/dff_pipe_reg.sv | 94 +++++++++
 tb/tb_dff_pipe_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dff_pipe_reg_pkg.sv
// Shared definitions for the D-flip-flop pipeline family: counter width helper,
// reset defaults and the per-edge operation decode used by every register.
package dff_pipe_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // One operation per edge, in priority order rst > flush > en > hold.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_FLUSH = 2'd2,
    OP_RESET = 2'd3
  } stage_op_e;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  function automatic stage_op_e decode_op(input logic rst, input logic flush,
                                          input logic en);
    if (rst)        return OP_RESET;
    else if (flush) return OP_FLUSH;
    else if (en)    return OP_SHIFT;
    else            return OP_HOLD;
  endfunction

endpackage

// File: rtl/dff_en_stage.sv
// One pipeline stage: a WIDTH-bit data register plus its valid bit, with
// synchronous reset, flush (valid only) and shift enable.
module dff_en_stage
  import dff_pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // NOTE: non-blocking assignments so every stage samples its neighbour's
  // pre-edge value; blocking here would collapse the chain into one stage.
  always_ff @(posedge clk) begin
    unique case (decode_op(rst, flush, en))
      OP_RESET: begin
        q       <= RESET_VAL;
        q_valid <= 1'b0;
      end
      OP_FLUSH: q_valid <= 1'b0;
      OP_SHIFT: begin
        q       <= d;
        q_valid <= d_valid;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dff_pipe_reg.sv
// WIDTH-bit, DEPTH-stage delay line with per-stage valid, stall, flush and occupancy
// count. Define DFF_PIPE_EDGE_EN to add the registered rise/fall edge outputs.
module dff_pipe_reg
  import dff_pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         d,
  input  logic                     d_valid,
  output logic [WIDTH-1:0]         out,
  output logic                     out_valid,
  output logic [cnt_w(DEPTH)-1:0]  fill_cnt
`ifdef DFF_PIPE_EDGE_EN
  ,
  output logic [WIDTH-1:0]         rise,
  output logic [WIDTH-1:0]         fall
`endif
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stage_data;
  logic [DEPTH-1:0]            stage_valid;
  stage_op_e                   op;

  assign op = decode_op(rst, flush, en);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] din;
    logic             vin;

    if (i == 0) begin : g_head
      assign din = d;
      assign vin = d_valid;
    end else begin : g_body
      assign din = stage_data[i-1];
      assign vin = stage_valid[i-1];
    end

    dff_en_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .flush   (flush),
      .d       (din),
      .d_valid (vin),
      .q       (stage_data[i]),
      .q_valid (stage_valid[i])
    );
  end

  assign out       = stage_data[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];

  // Modular arithmetic is safe: the result never exceeds DEPTH because a full
  // pipe always retires a valid entry on the same shift.
  always_ff @(posedge clk) begin
    unique case (op)
      OP_RESET, OP_FLUSH: fill_cnt <= '0;
      OP_SHIFT:           fill_cnt <= fill_cnt + CNT_W'(d_valid) - CNT_W'(out_valid);
      default: ;
    endcase
  end

`ifdef DFF_PIPE_EDGE_EN
  logic [WIDTH-1:0] next_out;

  if (DEPTH == 1) begin : g_next_d
    assign next_out = d;
  end else begin : g_next_stage
    assign next_out = stage_data[DEPTH-2];
  end

  always_ff @(posedge clk) begin
    if (op == OP_SHIFT) begin
      rise <= next_out & ~out;
      fall <= ~next_out & out;
    end else begin
      rise <= '0;
      fall <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_dff_pipe_reg.sv
// Directed bench for dff_pipe_reg (WIDTH=8, DEPTH=4): vector table for reset,
// latency, stall, flush and bubbles, plus a bounded latency-with-stall sequence.
module tb_dff_pipe_reg;

  logic       clk = 1'b0;
  logic       rst, en, flush, d_valid;
  logic [7:0] d;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] fill_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

`ifdef DFF_PIPE_EDGE_EN
  logic [7:0] rise, fall;
  logic       e_rst, e_en;
  logic [7:0] e_d, e_out, e_rise, e_fall;
  logic       e_ov;
  logic [0:0] e_fill;
`endif

  dff_pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .d         (d),
    .d_valid   (d_valid),
    .out       (out),
    .out_valid (out_valid),
    .fill_cnt  (fill_cnt)
`ifdef DFF_PIPE_EDGE_EN
    ,
    .rise      (rise),
    .fall      (fall)
`endif
  );

`ifdef DFF_PIPE_EDGE_EN
  dff_pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) dut_edge (
    .clk       (clk),
    .rst       (e_rst),
    .en        (e_en),
    .flush     (1'b0),
    .d         (e_d),
    .d_valid   (1'b1),
    .out       (e_out),
    .out_valid (e_ov),
    .fill_cnt  (e_fill),
    .rise      (e_rise),
    .fall      (e_fall)
  );
`endif

  typedef struct {
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       dv;
    logic [7:0] exp_out;
    logic       exp_ov;
    logic [2:0] exp_fill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic f, logic [7:0] dd, logic dv,
                              logic [7:0] eo, logic eov, logic [2:0] ef);
    vec_t v;
    v.rst = r; v.en = e; v.flush = f; v.d = dd; v.dv = dv;
    v.exp_out = eo; v.exp_ov = eov; v.exp_fill = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic e, input logic f,
                       input logic [7:0] dd, input logic dv);
    rst = r; en = e; flush = f; d = dd; d_valid = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cycles;
    rst = 1'b0; en = 1'b0; flush = 1'b0; d = '0; d_valid = 1'b0;
`ifdef DFF_PIPE_EDGE_EN
    e_rst = 1'b0; e_en = 1'b0; e_d = '0;
`endif

    //           rst en fl  d      dv  out    ov  fill
    vecs.push_back(mk(1, 1, 0, 8'hFF, 1, 8'h00, 0, 3'd0)); // reset wins over push
    vecs.push_back(mk(0, 1, 0, 8'hA1, 1, 8'h00, 0, 3'd1));
    vecs.push_back(mk(0, 1, 0, 8'hA2, 1, 8'h00, 0, 3'd2));
    vecs.push_back(mk(0, 1, 0, 8'hA3, 1, 8'h00, 0, 3'd3));
    vecs.push_back(mk(0, 1, 0, 8'hA4, 1, 8'hA1, 1, 3'd4)); // 4 edges after A1
    vecs.push_back(mk(0, 1, 0, 8'hB1, 1, 8'hA2, 1, 3'd4));
    vecs.push_back(mk(0, 0, 0, 8'hCC, 1, 8'hA2, 1, 3'd4)); // stall x3
    vecs.push_back(mk(0, 0, 0, 8'hCC, 1, 8'hA2, 1, 3'd4));
    vecs.push_back(mk(0, 0, 0, 8'hCC, 1, 8'hA2, 1, 3'd4));
    vecs.push_back(mk(0, 1, 0, 8'hB2, 1, 8'hA3, 1, 3'd4));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 8'hA4, 1, 3'd3));
    vecs.push_back(mk(0, 1, 1, 8'hDD, 1, 8'hA4, 0, 3'd0)); // flush: data holds
    vecs.push_back(mk(0, 1, 0, 8'hE1, 0, 8'hB1, 0, 3'd0));
    vecs.push_back(mk(0, 1, 0, 8'hE2, 0, 8'hB2, 0, 3'd0));
    vecs.push_back(mk(0, 1, 0, 8'hE3, 0, 8'h00, 0, 3'd0));
    vecs.push_back(mk(0, 1, 0, 8'hE4, 0, 8'hE1, 0, 3'd0));
    vecs.push_back(mk(0, 1, 0, 8'h51, 1, 8'hE2, 0, 3'd1)); // bubbles 1,0,1,0
    vecs.push_back(mk(0, 1, 0, 8'h52, 0, 8'hE3, 0, 3'd1));
    vecs.push_back(mk(0, 1, 0, 8'h53, 1, 8'hE4, 0, 3'd2));
    vecs.push_back(mk(0, 1, 0, 8'h54, 0, 8'h51, 1, 3'd2));
    vecs.push_back(mk(0, 1, 0, 8'h55, 1, 8'h52, 0, 3'd2));
    vecs.push_back(mk(0, 1, 0, 8'h56, 0, 8'h53, 1, 3'd2));
    vecs.push_back(mk(0, 1, 0, 8'h57, 1, 8'h54, 0, 3'd2));
    vecs.push_back(mk(1, 1, 0, 8'h99, 1, 8'h00, 0, 3'd0)); // mid-stream reset
    vecs.push_back(mk(0, 0, 0, 8'h77, 1, 8'h00, 0, 3'd0));
    vecs.push_back(mk(0, 1, 0, 8'h77, 1, 8'h00, 0, 3'd1));
    vecs.push_back(mk(0, 0, 1, 8'h66, 1, 8'h00, 0, 3'd0)); // flush with en=0

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].d, vecs[i].dv);
      check($sformatf("v%0d out", i),       32'(out),       32'(vecs[i].exp_out));
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("v%0d fill_cnt", i),  32'(fill_cnt),  32'(vecs[i].exp_fill));
    end

    // One valid token with a 2-cycle stall must emerge after 4+2 edges.
    drive(1, 1, 0, 8'h00, 0);
    drive(0, 1, 0, 8'h3C, 1);
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      if (cycles <= 2) drive(0, 0, 0, 8'h11, 1);
      else             drive(0, 1, 0, 8'h22, 0);
      cycles++;
    end
    check("stall latency", 32'(cycles), 32'd6);
    check("stall out", 32'(out), 32'h3C);
    check("stall fill", 32'(fill_cnt), 32'd1);

`ifdef DFF_PIPE_EDGE_EN
    begin
      logic [7:0] ed [5] = '{8'h00, 8'h00, 8'h0F, 8'hF0, 8'hAA};
      logic       ee [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic       er [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [7:0] xr [5] = '{8'h00, 8'h00, 8'h0F, 8'hF0, 8'h00};
      logic [7:0] xf [5] = '{8'h00, 8'h00, 8'h00, 8'h0F, 8'h00};
      for (int i = 0; i < 5; i++) begin
        e_rst = er[i]; e_en = ee[i]; e_d = ed[i];
        @(posedge clk);
        #1;
        check($sformatf("edge%0d rise", i), 32'(e_rise), 32'(xr[i]));
        check($sformatf("edge%0d fall", i), 32'(e_fall), 32'(xf[i]));
      end
      e_rst = 1'b1; e_en = 1'b1; e_d = 8'h00;
      @(posedge clk);
      #1;
      check("edge rst out", 32'(e_out), 32'h00);
      check("edge rst rise", 32'(e_rise), 32'h00);
      check("edge rst fall", 32'(e_fall), 32'h00);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
